// File: rtl/vertex_transform_pipe_pkg.sv
// Shared types, constants and arithmetic helpers for the vertex transform pipe.
// Clip helpers are compiled only when VTP_CLIP_FLAG_EN is defined.
package vertex_transform_pipe_pkg;

    localparam int DATAWIDTH = 24;
    localparam int FRACBITS  = 13;
    localparam int PROD_W    = 2 * DATAWIDTH;
    // Three full products plus a shifted bias need two guard bits.
    localparam int ACC_W     = PROD_W + 2;

    typedef logic signed [DATAWIDTH-1:0] word_t;
    typedef word_t [2:0] vec3_t;   // [0]=x [1]=y [2]=z
    typedef word_t [3:0] vec4_t;   // [0]=x [1]=y [2]=z [3]=w
    typedef vec4_t [3:0] mat4_t;   // m[row][col]

    localparam word_t ONE = word_t'(1 << FRACBITS);

    function automatic mat4_t identity_mat();
        mat4_t m;
        m = '0;
        for (int i = 0; i < 4; i++) m[i][i] = ONE;
        return m;
    endfunction

    localparam mat4_t IDENTITY = identity_mat();

    function automatic word_t sat_max();
        return {1'b0, {(DATAWIDTH-1){1'b1}}};
    endfunction

    function automatic word_t sat_min();
        return {1'b1, {(DATAWIDTH-1){1'b0}}};
    endfunction

    // Clamp a wide accumulator into the signed output word range.
    function automatic word_t saturate(input logic signed [ACC_W-1:0] a);
        if (a > ACC_W'(sat_max()))      return sat_max();
        else if (a < ACC_W'(sat_min())) return sat_min();
        else                            return a[DATAWIDTH-1:0];
    endfunction

`ifdef VTP_CLIP_FLAG_EN
    // One extra bit so that |most negative| is representable.
    function automatic logic signed [DATAWIDTH:0] mag(input word_t a);
        logic signed [DATAWIDTH:0] e;
        e = (DATAWIDTH+1)'(a);
        return (e < 0) ? -e : e;
    endfunction

    function automatic logic clip_test(input vec4_t v);
        logic signed [DATAWIDTH:0] w;
        w = (DATAWIDTH+1)'(word_t'(v[3]));
        return (w <= 0) | (mag(v[0]) > w) | (mag(v[1]) > w) | (mag(v[2]) > w);
    endfunction
`endif

    typedef struct packed {
`ifdef VTP_CLIP_FLAG_EN
        logic  clip;
`endif
        logic  last;
        vec4_t v;
    } fifo_entry_t;

endpackage

// File: rtl/vertex_transform_pipe_if.sv
// Stream, matrix-load and status signals of the vertex transform pipe.
// The slave modport is the pipe's view; master is the driving environment.
interface vertex_transform_pipe_if;
    import vertex_transform_pipe_pkg::*;

    mat4_t i_mvp_matrix;
    logic  i_mvp_dv;
    logic  o_mvp_err;
    vec3_t i_vertex;
    logic  i_vertex_dv;
    logic  i_vertex_last;
    logic  o_ready;
    vec4_t o_vertex;
    logic  o_vertex_clip;
    logic  o_vertex_dv;
    logic  i_ready;
    logic  o_finished;
    logic  o_busy;

    modport slave (
        input  i_mvp_matrix, i_mvp_dv, i_vertex, i_vertex_dv, i_vertex_last, i_ready,
        output o_mvp_err, o_ready, o_vertex, o_vertex_clip, o_vertex_dv, o_finished, o_busy
    );

    modport master (
        output i_mvp_matrix, i_mvp_dv, i_vertex, i_vertex_dv, i_vertex_last, i_ready,
        input  o_mvp_err, o_ready, o_vertex, o_vertex_clip, o_vertex_dv, o_finished, o_busy
    );
endinterface

// File: rtl/vtp_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; the head entry is always
// visible on dout_o. Push and pop may coincide at any fill level.
module vtp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;

    // Storage write.
    // NOTE: the storage array has no reset; only pointers and count carry
    // meaning after reset, and resetting the array would cost a mux per bit.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    // Pointer and occupancy tracking.
    // NOTE: all state updates use non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
endmodule

// File: rtl/vertex_transform_pipe.sv
// Three-stage MVP vertex transform (products / sum+shift / saturate) feeding a
// show-ahead output FIFO under credit flow control, so the pipeline never stalls.
// Optional macro VTP_CLIP_FLAG_EN adds the clip-volume flag to each output vertex.
module vertex_transform_pipe
    import vertex_transform_pipe_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    vertex_transform_pipe_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    mat4_t                     mat_q;
    logic                      mvp_err_q;
    logic                      s1_valid_q, s1_last_q, s2_valid_q, s2_last_q;
    logic signed [PROD_W-1:0]  prod_q [4][3];
    word_t                     bias_q [4];
    logic signed [ACC_W-1:0]   sum_d  [4];
    logic signed [ACC_W-1:0]   sum_q  [4];
    fifo_entry_t               push_entry, head_entry;
    logic [CNT_W-1:0]          fifo_count;
    logic [CNT_W:0]            occupancy;
    logic                      fifo_empty, pop, in_xfer, load_ok, ready, busy;

    // Every vertex accepted holds a credit until it leaves the FIFO.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid_q}
                     + {{CNT_W{1'b0}}, s2_valid_q};
    assign ready     = occupancy < (CNT_W+1)'(FIFO_DEPTH);
    assign busy      = (fifo_count != '0) | s1_valid_q | s2_valid_q;
    assign in_xfer   = bus.i_vertex_dv & ready;
    assign load_ok   = bus.i_mvp_dv & ~busy & ~in_xfer;
    assign pop       = ~fifo_empty & bus.i_ready;

    // Matrix register and load-rejection pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mat_q     <= IDENTITY;
            mvp_err_q <= 1'b0;
        end else begin
            if (load_ok) mat_q <= bus.i_mvp_matrix;
            mvp_err_q <= bus.i_mvp_dv & ~load_ok;
        end
    end

    // Valid and last flags travelling alongside the data stages.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= in_xfer;
            s1_last_q  <= in_xfer & bus.i_vertex_last;
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
        end
    end

    // S1: full-width products of the three spatial columns plus the translation term.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 3; c++) begin
                    prod_q[r][c] <= PROD_W'(word_t'(mat_q[r][c])) * PROD_W'(word_t'(bus.i_vertex[c]));
                end
                bias_q[r] <= mat_q[r][3];
            end
        end
    end

    // S2 combinational: accumulate, add w = 1.0 translation, drop fraction (floor).
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            sum_d[r] = (ACC_W'(prod_q[r][0]) + ACC_W'(prod_q[r][1]) + ACC_W'(prod_q[r][2])
                       + (ACC_W'(bias_q[r]) <<< FRACBITS)) >>> FRACBITS;
        end
    end

    // S2 register.
    always_ff @(posedge clk) begin
        if (s1_valid_q) begin
            for (int r = 0; r < 4; r++) sum_q[r] <= sum_d[r];
        end
    end

    // S3: saturate each component and assemble the FIFO entry.
    // NOTE: the entry gets a full default first so no field can hold its
    // value across evaluations and infer a latch.
    always_comb begin
        push_entry = '0;
        for (int r = 0; r < 4; r++) push_entry.v[r] = saturate(sum_q[r]);
        push_entry.last = s2_last_q;
`ifdef VTP_CLIP_FLAG_EN
        push_entry.clip = clip_test(push_entry.v);
`endif
    end

    vtp_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (s2_valid_q),
        .din_i   (push_entry),
        .pop_i   (pop),
        .dout_o  (head_entry),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    assign bus.o_ready     = ready;
    assign bus.o_busy      = busy;
    assign bus.o_mvp_err   = mvp_err_q;
    assign bus.o_vertex_dv = ~fifo_empty;
    assign bus.o_vertex    = fifo_empty ? '0 : head_entry.v;
    assign bus.o_finished  = ~fifo_empty & head_entry.last;
`ifdef VTP_CLIP_FLAG_EN
    assign bus.o_vertex_clip = ~fifo_empty & head_entry.clip;
`else
    assign bus.o_vertex_clip = 1'b0;
`endif
endmodule

// File: doc/vertex_transform_pipe.md
# vertex_transform_pipe

Parametrised, fully pipelined MVP vertex transform stage with ready/valid backpressure, an output FIFO, saturating fixed-point arithmetic and end-of-mesh tracking. It accepts one object-space vertex per cycle, multiplies it by a latched 4x4 MVP matrix (implicit w = 1.0) and delivers clip-space vertices to the vertex post-processor. It replaces the enable-gated vertex-shader hookup with a streaming interface that never drops vertices.

## Interface
- DATAWIDTH, 24, signed fixed-point width of matrix, input and output words
- FRACBITS, 13, fractional bits (1.0 = 1<<FRACBITS)
- FIFO_DEPTH, 8, output FIFO entries, power of two, ≥4
- clk  in  1  single clock, all state on rising edge
- rstn  in  1  reset, asynchronous and active-low
- i_mvp_matrix  in  [4][4]×DATAWIDTH signed  row-major MVP matrix
- i_mvp_dv  in  1  load request for i_mvp_matrix
- o_mvp_err  out  1  one-cycle pulse: load rejected
- i_vertex  in  [3]×DATAWIDTH signed  x, y, z
- i_vertex_dv  in  1  input valid
- i_vertex_last  in  1  marks final vertex of mesh, qualified by i_vertex_dv
- o_ready  out  1  input ready; transfer = i_vertex_dv & o_ready
- o_vertex  out  [4]×DATAWIDTH signed  x, y, z, w clip-space
- o_vertex_clip  out  1  vertex outside clip volume (see Configuration)
- o_vertex_dv  out  1  output valid
- i_ready  in  1  downstream ready; transfer = o_vertex_dv & i_ready
- o_finished  out  1  high with the output beat carrying the last flag
- o_busy  out  1  any vertex in pipeline or FIFO

## Operation
- Matrix register resets to identity. Load accepted only when o_busy = 0 and no input transfer is occurring that cycle; otherwise the matrix is unchanged and o_mvp_err pulses next cycle.
- Per row r: acc = Σc m[r][c]·v[c] (c = 0..2, full 2·DATAWIDTH products) + (m[r][3] <<< FRACBITS); result = acc >>> FRACBITS (arithmetic, truncating), saturated to [−2^(DATAWIDTH−1), 2^(DATAWIDTH−1)−1].
- Pipeline: S1 register products, S2 sum and shift, S3 saturate and write to FIFO. Valid and last flags travel with data.
- Credit flow control: o_ready = (fifo_count + inflight) < FIFO_DEPTH. The pipeline itself never stalls and the FIFO never overflows.
- FIFO is show-ahead: the head entry drives o_vertex/o_vertex_clip/o_finished whenever o_vertex_dv = 1. Simultaneous push and pop are permitted at any fill level, including full.
- o_finished is gated by o_vertex_dv; the last flag is per vertex, so back-to-back meshes are supported.
- Reset mid-operation discards all in-flight and buffered vertices and restores the identity matrix.
- Reset values: o_ready 1 (after release), o_vertex_dv 0, o_vertex 0, o_vertex_clip 0, o_finished 0, o_mvp_err 0, o_busy 0.

## Timing
- Latency: input transfer in cycle N → FIFO write at the end of N+2 → o_vertex_dv high in cycle N+3 (FIFO empty).
- Throughput: 1 vertex/cycle while i_ready = 1.
- o_ready drops combinationally from registered counts. It is asserted again in the cycle after an output pop frees a credit.
- A matrix load takes effect on the first vertex accepted in the cycle after the load.

## Configuration
- VTP_CLIP_FLAG_EN defined: S3 computes clip = (w ≤ 0) | (|x| > w) | (|y| > w) | (|z| > w) on the saturated values and stores it in the FIFO.
- Undefined: no clip logic; the FIFO omits the bit and o_vertex_clip is tied 0.

## Structure
- transform_pkg: vec3_t/vec4_t/mat4_t typedefs over DATAWIDTH, the SAT_MAX/SAT_MIN functions, and the identity-matrix constant.
- Sub-module vtp_fifo: synchronous show-ahead FIFO with a count output, parametrised by width and depth.

## Test plan
- Identity matrix, vertex (8192, −16384, 4096) → o_vertex (8192, −16384, 4096, 8192) in cycle N+3, o_vertex_clip 0.
- m[0][3] = 8192 loaded while idle, vertex (0, 0, 0) → (8192, 0, 0, 8192). Same load while busy → o_mvp_err pulse, output (0, 0, 0, 8192).
- m[0][0] = 819200 (100.0), x = 163840 (20.0) → x saturates to 8388607. With x = −163840 → −8388608.
- i_ready = 0, 12 vertices offered → exactly 8 accepted, o_ready 0. Release i_ready → all 12 appear in order, no loss or duplicates.
- 3-vertex mesh with last on vertex 3, followed by a 2-vertex mesh → o_finished high on output beats 3 and 5 only.
- rstn asserted with 5 vertices buffered → o_vertex_dv 0 immediately. After release, identity is restored and o_busy = 0.
- With VTP_CLIP_FLAG_EN: vertex (16384, 0, 0) under identity → clip 1.
